// File: rtl/mat_stream_engine.sv
// mat_stream_engine: walks a dim0 x dim1 row-major matrix and runs ELEM, SCAL, TRANS or RSUM,
// driving an external fixed-latency FU and writing results back to memory.
// Optional feature: define PERF_CNT_EN to add the perf_cycles busy-cycle counter output.
module mat_stream_engine #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DIM_W  = 6,
  parameter int unsigned FU_LAT = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DIM_W-1:0]  dim0,
  input  logic [DIM_W-1:0]  dim1,
  input  logic [ADDR_W-1:0] base_a,
  input  logic [ADDR_W-1:0] base_b,
  input  logic [ADDR_W-1:0] base_c,
  input  logic [DATA_W-1:0] scalar,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr_a,
  output logic [ADDR_W-1:0] rd_addr_b,
  input  logic [DATA_W-1:0] rd_data_a,
  input  logic [DATA_W-1:0] rd_data_b,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              fu_valid,
  output logic [DATA_W-1:0] fu_a,
  output logic [DATA_W-1:0] fu_b,
  input  logic [DATA_W-1:0] fu_res
`ifdef PERF_CNT_EN
  ,
  output logic [31:0]       perf_cycles
`endif
);

  localparam logic [2:0]  OpElem  = 3'd1;
  localparam logic [2:0]  OpScal  = 3'd2;
  localparam logic [2:0]  OpTrans = 3'd3;
  localparam logic [2:0]  OpRsum  = 3'd4;
  localparam int unsigned CntW    = $clog2(FU_LAT + 1) + 1;

  typedef enum logic [2:0] {StIdle, StIssue, StDrain, StDone, StRload, StRwait, StRwrite} state_e;

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [DIM_W-1:0]    dim0_q, dim0_d, dim1_q, dim1_d, i_q, i_d, j_q, j_d;
  logic [ADDR_W-1:0]   base_a_q, base_a_d, base_b_q, base_b_d, base_c_q, base_c_d;
  logic [ADDR_W-1:0]   k_q, k_d, tk_q, tk_d;  // tk = j*dim0+i, the transposed offset
  logic [DATA_W-1:0]   scalar_q, scalar_d, acc_q, acc_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [FU_LAT:0]     pipe_vld_q, pipe_vld_d;
  logic [ADDR_W-1:0]   pipe_addr_q [FU_LAT+1];
  logic [ADDR_W-1:0]   pipe_addr_d [FU_LAT+1];
  logic                pipe_in_vld;
  logic [ADDR_W-1:0]   pipe_in_addr;
  logic                op_pipe, op_trans, last_row, last_col;

  assign op_pipe  = (op_q == OpElem) || (op_q == OpScal);
  assign op_trans = (op_q == OpTrans);
  assign last_row = (i_q == dim0_q - DIM_W'(1));
  assign last_col = (j_q == dim1_q - DIM_W'(1));

  // Next-state, counter sequencing and all strobes/buses (zero unless their strobe is high).
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    dim0_d       = dim0_q;
    dim1_d       = dim1_q;
    base_a_d     = base_a_q;
    base_b_d     = base_b_q;
    base_c_d     = base_c_q;
    scalar_d     = scalar_q;
    err_d        = err_q;
    i_d          = i_q;
    j_d          = j_q;
    k_d          = k_q;
    tk_d         = tk_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    pipe_in_vld  = 1'b0;
    pipe_in_addr = '0;
    busy         = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    rd_en        = 1'b0;
    rd_addr_a    = '0;
    rd_addr_b    = '0;
    wr_en        = 1'b0;
    wr_addr      = '0;
    wr_data      = '0;
    fu_valid     = 1'b0;
    fu_a         = '0;
    fu_b         = '0;

    case (state_q)
      StIdle: begin
        if (start) begin
          op_d     = op;
          dim0_d   = dim0;
          dim1_d   = dim1;
          base_a_d = base_a;
          base_b_d = base_b;
          base_c_d = base_c;
          scalar_d = scalar;
          i_d      = '0;
          j_d      = '0;
          k_d      = '0;
          tk_d     = '0;
          if ((op == 3'd0) || (op > OpRsum) || (dim0 == '0) || (dim1 == '0)) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            err_d   = 1'b0;
            state_d = (op == OpRsum) ? StRload : StIssue;
          end
        end
      end
      StIssue: begin
        busy         = 1'b1;
        rd_en        = 1'b1;
        pipe_in_vld  = 1'b1;
        pipe_in_addr = base_c_q + (op_trans ? tk_q : k_q);
        k_d          = k_q + ADDR_W'(1);
        if (last_col) begin
          j_d  = '0;
          i_d  = i_q + DIM_W'(1);
          tk_d = ADDR_W'(i_q) + ADDR_W'(1);
        end else begin
          j_d  = j_q + DIM_W'(1);
          tk_d = tk_q + ADDR_W'(dim0_q);
        end
        if (last_row && last_col) state_d = StDrain;
      end
      StDrain: begin
        busy = 1'b1;
        // Empty next cycle once only the exiting stage (or a TRANS stage 0) still holds data.
        if (op_trans || (pipe_vld_q[FU_LAT-1:0] == '0)) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        err     = err_q;
        state_d = StIdle;
      end
      StRload: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        k_d     = k_q + ADDR_W'(1);
        cnt_d   = '0;
        state_d = StRwait;
      end
      StRwait: begin
        busy = 1'b1;
        if (cnt_q == '0) begin
          if (j_q == '0) begin
            acc_d = rd_data_a;
            if (last_col) begin
              state_d = StRwrite;
            end else begin
              j_d     = j_q + DIM_W'(1);
              state_d = StRload;
            end
          end else begin
            fu_valid = 1'b1;
            fu_a     = acc_q;
            fu_b     = rd_data_a;
            cnt_d    = CntW'(1);
          end
        end else if (cnt_q == CntW'(FU_LAT)) begin
          acc_d = fu_res;
          if (last_col) begin
            state_d = StRwrite;
          end else begin
            j_d     = j_q + DIM_W'(1);
            state_d = StRload;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRwrite: begin
        busy    = 1'b1;
        wr_en   = 1'b1;
        wr_addr = base_c_q + ADDR_W'(i_q);
        wr_data = acc_q;
        if (last_row) begin
          state_d = StDone;
        end else begin
          i_d     = i_q + DIM_W'(1);
          j_d     = '0;
          state_d = StRload;
        end
      end
      default: state_d = StIdle;
    endcase

    if (rd_en) begin
      rd_addr_a = base_a_q + k_q;
      rd_addr_b = base_b_q + k_q;
    end

    // Pipelined issue: data read last cycle goes to the FU (ELEM/SCAL) or straight out (TRANS).
    if (op_pipe && pipe_vld_q[0]) begin
      fu_valid = 1'b1;
      fu_a     = rd_data_a;
      fu_b     = (op_q == OpScal) ? scalar_q : rd_data_b;
    end
    if (op_trans && pipe_vld_q[0]) begin
      wr_en   = 1'b1;
      wr_addr = pipe_addr_q[0];
      wr_data = rd_data_a;
    end else if (op_pipe && pipe_vld_q[FU_LAT]) begin
      wr_en   = 1'b1;
      wr_addr = pipe_addr_q[FU_LAT];
      wr_data = fu_res;
    end
  end

  // Write-address/valid shift pipeline; TRANS retires from stage 0 so it never shifts onward.
  always_comb begin
    pipe_vld_d     = pipe_vld_q;
    pipe_addr_d    = pipe_addr_q;
    pipe_vld_d[0]  = pipe_in_vld;
    pipe_addr_d[0] = pipe_in_addr;
    for (int n = 1; n <= int'(FU_LAT); n++) begin
      pipe_vld_d[n]  = pipe_vld_q[n-1] && !op_trans;
      pipe_addr_d[n] = pipe_addr_q[n-1];
    end
  end

  // State, command and counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= '0;
      dim0_q   <= '0;
      dim1_q   <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      base_c_q <= '0;
      scalar_q <= '0;
      err_q    <= 1'b0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      tk_q     <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      dim0_q   <= dim0_d;
      dim1_q   <= dim1_d;
      base_a_q <= base_a_d;
      base_b_q <= base_b_d;
      base_c_q <= base_c_d;
      scalar_q <= scalar_d;
      err_q    <= err_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      tk_q     <= tk_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  // Pipeline registers; reset flushes in-flight writes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pipe_vld_q <= '0;
      for (int n = 0; n <= int'(FU_LAT); n++) pipe_addr_q[n] <= '0;
    end else begin
      pipe_vld_q  <= pipe_vld_d;
      pipe_addr_q <= pipe_addr_d;
    end
  end

`ifdef PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  // Busy-cycle counter: cleared on accept, held once idle.
  always_comb begin
    perf_d = perf_q;
    if (state_q == StIdle && start) perf_d = '0;
    else if (busy)                  perf_d = perf_q + 32'd1;
  end

  // Counter register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) perf_q <= '0;
    else       perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`endif

endmodule

// File: tb/tb_mat_stream_engine.sv
// Scoreboard bench for mat_stream_engine: memory and adder-FU models, reference results
// computed per command, and a monitor that checks writes and completion as they appear.
module tb_mat_stream_engine;
  localparam int DW  = 32;
  localparam int AW  = 12;
  localparam int DMW = 6;
  localparam int LAT = 3;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [2:0]     op = '0;
  logic [DMW-1:0] dim0 = '0, dim1 = '0;
  logic [AW-1:0]  base_a = '0, base_b = '0, base_c = '0;
  logic [DW-1:0]  scalar = '0;
  logic           busy, done, err, rd_en, wr_en, fu_valid;
  logic [AW-1:0]  rd_addr_a, rd_addr_b, wr_addr;
  logic [DW-1:0]  rd_data_a, rd_data_b, wr_data, fu_a, fu_b, fu_res;
`ifdef PERF_CNT_EN
  logic [31:0]    perf_cycles;
`endif

  mat_stream_engine #(.DATA_W(DW), .ADDR_W(AW), .DIM_W(DMW), .FU_LAT(LAT)) dut (
    .clock(clock), .reset(reset), .start(start), .op(op), .dim0(dim0), .dim1(dim1),
    .base_a(base_a), .base_b(base_b), .base_c(base_c), .scalar(scalar),
    .busy(busy), .done(done), .err(err), .rd_en(rd_en), .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .fu_valid(fu_valid), .fu_a(fu_a), .fu_b(fu_b),
    .fu_res(fu_res)
`ifdef PERF_CNT_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Source memory, written only by the stimulus process; results go to the scoreboard.
  logic [DW-1:0] mem [4096];
  always @(posedge clock) begin
    rd_data_a <= rd_en ? mem[rd_addr_a] : 32'hdead_beef;
    rd_data_b <= rd_en ? mem[rd_addr_b] : 32'hdead_beef;
  end

  // Adder FU with exactly LAT cycles of latency.
  logic [DW-1:0] fu_sr [LAT];
  always @(posedge clock) begin
    fu_sr[0] <= fu_valid ? fu_a + fu_b : 32'hbad0_bad0;
    for (int n = 1; n < LAT; n++) fu_sr[n] <= fu_sr[n-1];
  end
  assign fu_res = fu_sr[LAT-1];

  typedef struct {logic [AW-1:0] addr; logic [DW-1:0] data;} wr_t;
  typedef struct {int acc; int lat; bit err; int n_rd; int n_fu;} cmd_t;
  wr_t  exp_q [$];
  cmd_t cmd_q [$];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %0h, required none (cycle %0d)", name, act, cyc);
  endtask

  // Monitor: compares every write and every done against the scoreboard.
  bit   rst_checked = 1'b0;
  int   rd_cnt = 0, fu_cnt = 0;
  wr_t  mw;
  cmd_t mc;
  always @(negedge clock) begin
    if (reset) begin
      if (!rst_checked) begin
        chk("reset_strobes", {58'd0, busy, done, err, rd_en, wr_en, fu_valid}, 64'd0);
        chk("reset_buses", {63'd0, |{rd_addr_a, rd_addr_b, wr_addr, wr_data, fu_a, fu_b}},
            64'd0);
        rst_checked = 1'b1;
      end
      exp_q.delete();
      cmd_q.delete();
      rd_cnt = 0;
      fu_cnt = 0;
    end else begin
      rst_checked = 1'b0;
      if (rd_en) rd_cnt++;
      if (fu_valid) fu_cnt++;
      if (wr_en) begin
        if (exp_q.size() == 0) fail_now("unexpected_write", {52'd0, wr_addr});
        else begin
          mw = exp_q.pop_front();
          chk("wr_addr", 64'(wr_addr), 64'(mw.addr));
          chk("wr_data", 64'(wr_data), 64'(mw.data));
        end
      end
      if (cmd_q.size() > 0) begin
        if (cyc == cmd_q[0].acc + 1) chk("busy_after_accept", 64'(busy), 64'(!cmd_q[0].err));
        if (done) begin
          mc = cmd_q.pop_front();
          chk("err_flag", 64'(err), 64'(mc.err));
          if (mc.lat >= 0) chk("done_latency", 64'(cyc - mc.acc), 64'(mc.lat));
          chk("rd_count", 64'(rd_cnt), 64'(mc.n_rd));
          chk("fu_count", 64'(fu_cnt), 64'(mc.n_fu));
          chk("busy_with_done", 64'(busy), 64'd0);
          chk("wr_with_done", 64'(wr_en), 64'd0);
          chk("writes_left", 64'(exp_q.size()), 64'd0);
          rd_cnt = 0;
          fu_cnt = 0;
        end else if (cyc - cmd_q[0].acc > 800) begin
          fail_now("done_timeout", 64'(cyc - cmd_q[0].acc));
          void'(cmd_q.pop_front());
          exp_q.delete();
        end
      end else if (done) begin
        fail_now("unexpected_done", 64'(err));
      end
    end
  end

  // mode 0: plain; 1: second start while busy; 2: reset after the fifth element read.
  task automatic run_cmd(input int o, input int d0, input int d1, input int ba, input int bb,
                         input int bc, input logic [DW-1:0] sc, input bit directed,
                         input int mode);
    int   n;
    bit   legal;
    cmd_t c;
    wr_t  w;
    logic [DW-1:0] a [];
    logic [DW-1:0] b [];
    logic [DW-1:0] s;
    int   seen;
    n     = d0 * d1;
    legal = (o >= 1) && (o <= 4) && (d0 > 0) && (d1 > 0);
    a     = new[n];
    b     = new[n];
    for (int k = 0; k < n; k++) begin
      a[k] = directed ? DW'(k + 1) : $urandom;
      b[k] = directed ? DW'(10 * (k + 1)) : $urandom;
      mem[(ba + k) % 4096] = a[k];
      mem[(bb + k) % 4096] = b[k];
    end
    c.acc = cyc;
    c.err = !legal;
    c.n_rd = legal ? n : 0;
    c.n_fu = 0;
    c.lat = 1;
    if (legal) begin
      case (o)
        1, 2: begin
          c.n_fu = n;
          c.lat  = n + LAT + 2;
          for (int k = 0; k < n; k++) begin
            w.addr = AW'((bc + k) % 4096);
            w.data = a[k] + ((o == 1) ? b[k] : sc);
            exp_q.push_back(w);
          end
        end
        3: begin
          c.lat = n + 2;
          for (int i = 0; i < d0; i++)
            for (int j = 0; j < d1; j++) begin
              w.addr = AW'((bc + j * d0 + i) % 4096);
              w.data = a[i * d1 + j];
              exp_q.push_back(w);
            end
        end
        default: begin
          c.n_fu = d0 * (d1 - 1);
          c.lat  = -1;
          for (int i = 0; i < d0; i++) begin
            s = '0;
            for (int j = 0; j < d1; j++) s += a[i * d1 + j];
            w.addr = AW'((bc + i) % 4096);
            w.data = s;
            exp_q.push_back(w);
          end
        end
      endcase
    end
    cmd_q.push_back(c);
    op = 3'(o); dim0 = DMW'(d0); dim1 = DMW'(d1);
    base_a = AW'(ba); base_b = AW'(bb); base_c = AW'(bc); scalar = sc;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    if (mode == 1) begin
      repeat (2) @(negedge clock);
      op = 3'd3; dim0 = 6'd1; dim1 = 6'd1; base_c = 12'd50; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    if (mode == 2) begin
      seen = 0;
      for (int t = 0; t < 40 && seen < 5; t++) begin
        @(negedge clock);
        if (rd_en) seen++;
      end
      @(posedge clock);
      #1 reset = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b0;
      repeat (20) @(negedge clock);
    end else begin
      for (int t = 0; t < 1000 && cmd_q.size() > 0; t++) @(negedge clock);
      repeat (2) @(negedge clock);
    end
  endtask

  initial begin
    int o, d0, d1;
    for (int k = 0; k < 4096; k++) mem[k] = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    // Directed cases from the command set
    run_cmd(1, 2, 3, 100, 1200, 3000, 32'd0, 1'b1, 0);
    run_cmd(2, 1, 4, 110, 1210, 3010, 32'd5, 1'b1, 0);
    run_cmd(3, 2, 3, 120, 1220, 3020, 32'd0, 1'b1, 0);
    run_cmd(4, 2, 3, 130, 1230, 3030, 32'd0, 1'b1, 0);
    run_cmd(1, 0, 3, 140, 1240, 3040, 32'd0, 1'b1, 0);
    run_cmd(6, 2, 2, 140, 1240, 3040, 32'd0, 1'b1, 0);
    run_cmd(4, 3, 1, 150, 1250, 3050, 32'd0, 1'b0, 0);
    run_cmd(1, 2, 2, 160, 1260, 4094, 32'd0, 1'b0, 0);
    run_cmd(1, 3, 3, 170, 1270, 3070, 32'd0, 1'b0, 1);
    // Randomized commands
    for (int r = 0; r < 40; r++) begin
      o  = $urandom_range(1, 4);
      d0 = $urandom_range(1, 5);
      d1 = $urandom_range(1, 5);
      if ($urandom_range(0, 9) == 0) o = $urandom_range(5, 7);
      if ($urandom_range(0, 14) == 0) d1 = 0;
      run_cmd(o, d0, d1, 100 + $urandom_range(0, 999), 1200 + $urandom_range(0, 999),
              3000 + $urandom_range(0, 1095), $urandom, 1'b0, 0);
    end
    // Reset in the middle of a 4x4 ELEM, then confirm recovery
    run_cmd(1, 4, 4, 200, 1300, 3100, 32'd0, 1'b0, 2);
    run_cmd(2, 2, 2, 210, 1310, 3110, 32'd7, 1'b0, 0);
    repeat (3) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d, required finish", cyc);
    $fatal(1, "bench did not finish");
  end
endmodule

// File: doc/mat_stream_engine.md
Name: mat_stream_engine

Overview:
- Parametrised matrix sequencer for the FPGA tensor ALU.
- Walks a dim0 x dim1 row-major matrix in on-chip memory and performs one of four operations: elementwise, scalar, transpose or row-reduce.
- Drives an external fixed-latency floating-point unit (FU) and writes results back.
- Sits between the op decoder and the MemControl/FP IP. Generalises the single-mode add FSM to multiple modes, runtime dimensions and pipelined throughput.

Parameters:
DATA_W, 32, element width (IEEE single)
ADDR_W, 12, memory word address width
DIM_W, 6, width of each dimension (max 63)
FU_LAT, 7, FU result latency in cycles (>=1)

Ports:
clock  in  1  clock
reset  in  1  async active-high reset
start  in  1  one-cycle command strobe; sampled only in IDLE
op  in  3  0 NONE, 1 ELEM (A op B), 2 SCAL (A op scalar), 3 TRANS, 4 RSUM
dim0  in  DIM_W  rows
dim1  in  DIM_W  columns
base_a  in  ADDR_W  A base address
base_b  in  ADDR_W  B base address
base_c  in  ADDR_W  C base address
scalar  in  DATA_W  scalar operand
busy  out  1  high from accept until done
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse with done on illegal command
rd_en  out  1  read strobe; data valid next cycle
rd_addr_a  out  ADDR_W  read address, port A
rd_addr_b  out  ADDR_W  read address, port B
rd_data_a  in  DATA_W  read data, port A
rd_data_b  in  DATA_W  read data, port B
wr_en  out  1  write strobe
wr_addr  out  ADDR_W  write address
wr_data  out  DATA_W  write data
fu_valid  out  1  FU issue strobe
fu_a  out  DATA_W  FU operand a
fu_b  out  DATA_W  FU operand b
fu_res  in  DATA_W  FU result, valid exactly FU_LAT cycles after fu_valid

Behaviour:
- Reset: async. All outputs 0, state IDLE, counters 0, in-flight pipeline flushed. No write occurs after reset asserts mid-operation.
- Command accept: start=1 in IDLE latches op, dims, bases and scalar. busy rises next cycle. start while busy is ignored.
- Illegal command: op=NONE, op>4, dim0=0 or dim1=0. Produces done=err=1 one cycle after start, with no memory or FU activity.
- Counters: i (row), j (col) as DIM_W counters. Linear index k=i*dim1+j. All addresses are base+offset modulo 2^ADDR_W (wrap, no error).
- States: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE for ELEM/SCAL/TRANS; IDLE -> RLOAD -> RWAIT -> RWRITE -> (RLOAD | DONE) for RSUM.
- ELEM/SCAL issue:
  - One element per cycle: rd_en at cycle t with rd_addr_a=base_a+k (and rd_addr_b=base_b+k).
  - Cycle t+1: fu_valid=1, fu_a=rd_data_a, fu_b=rd_data_b or scalar.
  - Cycle t+1+FU_LAT: wr_en=1, wr_addr=base_c+k, wr_data=fu_res.
  - Write address tracked by a FU_LAT+1 deep address/valid shift pipeline.
- TRANS: rd_addr_a=base_a+i*dim1+j at t. At t+1: wr_addr=base_c+j*dim0+i, wr_data=rd_data_a. FU unused.
- DRAIN: wait until the pipeline is empty. done pulses the cycle after the last write; busy falls with done.
- Throughput / latency:
  - ELEM/SCAL: N=dim0*dim1 cycles to issue; done at accept+N+FU_LAT+2.
  - TRANS: done at accept+N+2.
- RSUM (non-pipelined, sum over columns):
  - Per row i: read A[i][0] into acc.
  - For j=1..dim1-1: read A[i][j], issue fu_a=acc, fu_b=data, wait FU_LAT, acc=fu_res.
  - Then write C[base_c+i]=acc.
  - dim1=1 copies the column.
- Simultaneous events: final write and done never share a cycle. wr_en and rd_en may coincide.

Optional Feature:
PERF_CNT_EN: adds output perf_cycles[31:0], counting cycles while busy. Cleared on accept, held after done, 0 on reset. Without the macro the port is absent and there is no counter logic.

Test Plan:
- ELEM 2x3, A=1..6, B=10..60, FU=add model, FU_LAT=3 -> C=11,22,33,44,55,66 at base_c..+5; done at accept+11.
- SCAL 1x4, A=1..4, scalar=5 -> C=6,7,8,9; exactly 4 fu_valid pulses.
- TRANS 2x3, A=[1 2 3;4 5 6] -> C=1,4,2,5,3,6; done at accept+8; fu_valid never asserted.
- RSUM 2x3, A=1..6, FU_LAT=3 -> C[0]=6, C[1]=15; exactly 2 writes.
- dim0=0 or op=6 -> done=err=1 at accept+1; rd_en/wr_en/fu_valid stay 0.
- Reset mid-ELEM 4x4 at element 5 -> all outputs 0 immediately, no further wr_en; second start while busy ignored (busy, op unchanged).
